// File: rtl/mnist_pixel_packer.sv
// MNIST input stage: binarises a stream of 8-bit pixels and packs a full frame for the layer-0 LUTs.
// Build macro PIXEL_PACKER_DBUF_EN lets the next frame fill while the packed output is held.
module mnist_pixel_packer #(
  parameter int N_PIXELS = 784,
  parameter int PIX_W    = 8,
  parameter int THRESH   = 128,
  parameter int CNT_W    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [PIX_W-1:0]    s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [N_PIXELS-1:0] m_data,
  output logic                err_len
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIXELS - 1);
  localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESH);

  state_e              state;
  state_e              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [N_PIXELS-1:0] fill;
  logic [N_PIXELS-1:0] fill_next;
  logic                pix_acc;
  logic                frm_acc;
  logic                pix_bit;
  logic                at_last;
  logic                done;
  logic                early;
  logic                s_ready_next;

  assign pix_acc = s_valid && s_ready;
  assign frm_acc = m_valid && m_ready;
  assign pix_bit = (s_data >= THRESH_V);
  assign at_last = (cnt == LAST_IDX);
  assign done    = pix_acc && at_last;
  assign early   = pix_acc && !at_last && s_last;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    fill_next      = fill;
    fill_next[cnt] = pix_bit;
  end

  always_comb begin
    cnt_next = cnt;
    if (done || early) begin
      cnt_next = '0;
    end else if (pix_acc) begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Completion and output handshake never coincide: s_ready is low whenever a frame is held
  // and the counter sits on the last pixel.
  always_comb begin
    state_next = state;
    if (done) begin
      state_next = HOLD;
    end else if (frm_acc) begin
      state_next = FILL;
    end
  end

`ifdef PIXEL_PACKER_DBUF_EN
  // Keep filling while the output is held, but refuse the completing pixel until it drains.
  assign s_ready_next = !((state_next == HOLD) && (cnt_next == LAST_IDX));
`else
  assign s_ready_next = (state_next == FILL);
`endif

  // NOTE: the fill buffer is deliberately left without reset; every bit is rewritten before
  // the next completion, so stale contents never reach m_data.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      fill <= fill_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      cnt     <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      err_len <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      s_ready <= s_ready_next;
      m_valid <= (state_next == HOLD);
      err_len <= early || (done && !s_last);
      if (done) begin
        m_data <= fill_next;
      end
    end
  end

endmodule

// File: tb/tb_mnist_pixel_packer.sv
// Self-checking bench for mnist_pixel_packer: directed scenarios with random pixel content,
// expected frames computed from the thresholding rule over a pixel array.
module tb_mnist_pixel_packer;

  localparam int N = 784;
`ifdef PIXEL_PACKER_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_last  = 1'b0;
  logic         m_ready = 1'b0;
  logic [7:0]   s_data  = 8'd0;
  logic         s_ready;
  logic         m_valid;
  logic         err_len;
  logic [N-1:0] m_data;

  int           vectors     = 0;
  int           miscompares = 0;
  int           err_seen    = 0;
  int           err_base;
  logic [7:0]   pix [N];
  logic [N-1:0] exp_a;
  logic [N-1:0] exp_b;

  mnist_pixel_packer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_len === 1'b1) err_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] req);
    int diff = -1;
    vectors++;
    for (int i = N - 1; i >= 0; i--) if (obs[i] !== req[i]) diff = i;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h required=%0h (low 64 bits, first differing bit %0d)",
             tag, obs[63:0], req[63:0], diff);
    end
  endtask

  // Expected frame: bit i is set when pixel i reaches the threshold.
  function automatic logic [N-1:0] model_frame();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (pix[i] >= 8'd128);
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) pix[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    int waited = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("s_ready_wait", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) push(pix[i], (i == last_at));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data",  m_data,  '0);
    check("rst_err_len", err_len, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", s_ready, 1'b1);

    // Ramp frame, consumer always ready
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) pix[i] = 8'(i % 256);
    exp_a = model_frame();
    send_frame(N, N - 1);
    @(negedge clk);
    check("ramp_m_valid", m_valid, 1'b1);
    check("ramp_m_data",  m_data,  exp_a);
    check("ramp_s_ready", s_ready, DBUF);
    check("ramp_err_len", err_len, 1'b0);
    @(negedge clk);
    check("ramp_m_valid_drop", m_valid, 1'b0);
    check("ramp_s_ready_back", s_ready, 1'b1);
    check("ramp_m_data_kept",  m_data,  exp_a);
    check("ramp_no_err", 32'(err_seen), 32'd0);

    // Threshold edges at positions 0-3
    fill_random();
    pix[0] = 8'd127; pix[1] = 8'd128; pix[2] = 8'd0; pix[3] = 8'd255;
    exp_a = model_frame();
    send_frame(N, N - 1);
    @(negedge clk);
    check("thr_m_valid", m_valid, 1'b1);
    check("thr_bits",    m_data[3:0], 4'b1010);
    check("thr_m_data",  m_data, exp_a);

    // Early s_last on pixel 99, then a clean frame
    err_base = err_seen;
    fill_random();
    send_frame(100, 99);
    @(negedge clk);
    check("early_err_len", err_len, 1'b1);
    check("early_m_valid", m_valid, 1'b0);
    check("early_m_data_unchanged", m_data, exp_a);
    @(negedge clk);
    check("early_err_len_one_cycle", err_len, 1'b0);
    fill_random();
    exp_a = model_frame();
    send_frame(N, N - 1);
    @(negedge clk);
    check("clean_m_valid", m_valid, 1'b1);
    check("clean_m_data",  m_data,  exp_a);
    check("clean_err_len", err_len, 1'b0);
    @(negedge clk);
    check("early_err_count", 32'(err_seen - err_base), 32'd1);

    // Full-length frame with no s_last
    err_base = err_seen;
    fill_random();
    exp_a = model_frame();
    send_frame(N, -1);
    @(negedge clk);
    check("nolast_m_valid", m_valid, 1'b1);
    check("nolast_err_len", err_len, 1'b1);
    check("nolast_m_data",  m_data,  exp_a);
    @(negedge clk);
    check("nolast_err_count", 32'(err_seen - err_base), 32'd1);

    // Back-pressure: consumer stalls after completion
    m_ready = 1'b0;
    fill_random();
    exp_a = model_frame();
    send_frame(N, N - 1);
    if (DBUF) begin
      fill_random();
      exp_b = model_frame();
      send_frame(N - 1, -1);
      check("dbuf_hold_m_valid", m_valid, 1'b1);
      check("dbuf_hold_m_data",  m_data,  exp_a);
      repeat (5) begin
        @(negedge clk);
        check("dbuf_stall_s_ready", s_ready, 1'b0);
        check("dbuf_stall_m_valid", m_valid, 1'b1);
      end
      m_ready = 1'b1;
      @(negedge clk);
      check("dbuf_drain_m_valid", m_valid, 1'b0);
      check("dbuf_drain_s_ready", s_ready, 1'b1);
      push(pix[N - 1], 1'b1);
      @(negedge clk);
      check("dbuf_next_m_valid", m_valid, 1'b1);
      check("dbuf_next_m_data",  m_data,  exp_b);
    end else begin
      repeat (50) begin
        @(negedge clk);
        check("hold_m_valid", m_valid, 1'b1);
        check("hold_m_data",  m_data,  exp_a);
        check("hold_s_ready", s_ready, 1'b0);
      end
      m_ready = 1'b1;
      @(negedge clk);
      check("hold_release_m_valid", m_valid, 1'b0);
      check("hold_release_s_ready", s_ready, 1'b1);
    end
    m_ready = 1'b1;

    // Reset pulse mid-frame
    err_base = err_seen;
    fill_random();
    send_frame(400, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_s_ready", s_ready, 1'b0);
    check("midrst_m_data",  m_data,  '0);
    @(negedge clk);
    check("midrst_hold_s_ready", s_ready, 1'b0);
    check("midrst_hold_err_len", err_len, 1'b0);
    rst_n = 1'b1;
    fill_random();
    exp_a = model_frame();
    send_frame(N - 1, -1);
    @(negedge clk);
    check("postrst_not_done", m_valid, 1'b0);
    push(pix[N - 1], 1'b1);
    @(negedge clk);
    check("postrst_m_valid", m_valid, 1'b1);
    check("postrst_m_data",  m_data,  exp_a);
    @(negedge clk);
    check("postrst_no_err", 32'(err_seen - err_base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
